// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: sequencer state encoding and
// default data width / FIFO depth used by uart_sync_fifo and uart_tx_fifo.
package uart_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular byte buffer with registered occupancy flags and a
// sticky overflow flag. Read data is the head entry, valid whenever !empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              wr_acc;
  logic              rd_acc;

  // Acceptance uses the registered flags, so a write while full is refused
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    wr_acc     = wr_en && !full_q;
    rd_acc     = rd_en && !empty_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (wr_en && full_q) overflow_d = 1'b1;
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer plus one-frame-in-flight sequencer feeding the UART transmitter.
// Optional UART_TX_FIFO_STATS_EN adds sent_count and hwm (occupancy high-water mark).
//
// state | meaning
// IDLE  | no frame in flight; pops the head byte when the FIFO is not empty
// SEND  | tx_newd held with stable tx_data until a rising edge of tx_done
// GAP   | frame finished; waits for tx_done low so the transmitter sees newd=0
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_FIFO_DEPTH,
  parameter int DATA_W = UART_DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         overflow,
  output logic                         tx_newd,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_done,
  output logic                         busy
`ifdef UART_TX_FIFO_STATS_EN
  ,
  output logic [15:0]                  sent_count,
  output logic [$clog2(DEPTH+1)-1:0]   hwm
`endif
);

  tx_state_e         state_q, state_d;
  logic              tx_newd_q, tx_newd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              tx_done_q;
  logic              done_rise;
  logic              pop;
  logic [DATA_W-1:0] rd_data;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  // A tx_done level already high when SEND is entered is not an edge.
  assign done_rise = tx_done && !tx_done_q;

  always_comb begin
    state_d   = state_q;
    tx_newd_d = tx_newd_q;
    tx_data_d = tx_data_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          tx_data_d = rd_data;
          tx_newd_d = 1'b1;
          state_d   = SEND;
        end else begin
          tx_newd_d = 1'b0;
        end
      end
      SEND: begin
        if (done_rise) begin
          tx_newd_d = 1'b0;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (!tx_done) state_d = IDLE;
      end
      default: begin
        tx_newd_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      tx_newd_q <= 1'b0;
      tx_data_q <= '0;
      busy_q    <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_newd_q <= tx_newd_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
      tx_done_q <= tx_done;
    end
  end

  assign tx_newd = tx_newd_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;

`ifdef UART_TX_FIFO_STATS_EN
  localparam int CW = $clog2(DEPTH + 1);

  logic [15:0]   sent_count_q, sent_count_d;
  logic [CW-1:0] hwm_q, hwm_d;

  always_comb begin
    sent_count_d = sent_count_q;
    if (state_q == SEND && done_rise && sent_count_q != 16'hFFFF)
      sent_count_d = sent_count_q + 16'd1;
    hwm_d = (count > hwm_q) ? count : hwm_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_count_q <= '0;
      hwm_q        <= '0;
    end else begin
      sent_count_q <= sent_count_d;
      hwm_q        <= hwm_d;
    end
  end

  assign sent_count = sent_count_q;
  assign hwm        = hwm_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model compared every cycle,
// a transmitter model answering tx_newd with tx_done pulses, and directed cases.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          tx_newd;
  logic [7:0]    tx_data;
  logic          tx_done;
  logic          busy;
`ifdef UART_TX_FIFO_STATS_EN
  logic [15:0]   sent_count;
  logic [CW-1:0] hwm;
`endif

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .tx_newd    (tx_newd),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy)
`ifdef UART_TX_FIFO_STATS_EN
    ,
    .sent_count (sent_count),
    .hwm        (hwm)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // transmitter model: auto mode answers newd, manual mode follows man_done
  logic       xm_auto, xm_rand, xm_done, man_done;
  int         xm_lat, xm_wid, xm_cnt, xm_ph;
  logic [7:0] frames [$];

  assign tx_done = xm_auto ? xm_done : man_done;

  always @(negedge clk) begin
    if (!xm_auto) begin
      xm_ph   = 0;
      xm_done = 1'b0;
    end else begin
      case (xm_ph)
        0: if (tx_newd === 1'b1) begin
             frames.push_back(tx_data);
             xm_cnt = xm_rand ? int'($urandom_range(0, 6)) : xm_lat;
             xm_ph  = 1;
           end
        1: if (xm_cnt == 0) begin
             xm_done = 1'b1;
             xm_cnt  = (xm_rand ? int'($urandom_range(1, 4)) : xm_wid) - 1;
             xm_ph   = 2;
           end else xm_cnt--;
        2: if (xm_cnt == 0) begin
             xm_done = 1'b0;
             xm_ph   = 3;
           end else xm_cnt--;
        default: if (tx_newd === 1'b0) xm_ph = 0;
      endcase
    end
  end

  // reference model: buffer contents as a queue, frame status as two flags
  logic [7:0] q_m [$];
  logic [7:0] cur_m;
  bit         in_flight_m, wait_low_m, ovf_m, done_prev_m;
  int         sent_m, hwm_m;

  always @(posedge clk) begin : model
    bit was_full, rise, take;
    if (rst) begin
      q_m.delete();
      cur_m = 8'h00; in_flight_m = 0; wait_low_m = 0; ovf_m = 0;
      done_prev_m = 0; sent_m = 0; hwm_m = 0;
    end else begin
      was_full = (q_m.size() == DEPTH);
      rise     = tx_done && !done_prev_m;
      take     = !in_flight_m && !wait_low_m && (q_m.size() != 0);
      if (q_m.size() > hwm_m) hwm_m = q_m.size();
      if (in_flight_m && rise) begin
        in_flight_m = 0;
        wait_low_m  = 1;
        if (sent_m < 65535) sent_m++;
      end else if (wait_low_m && !tx_done) begin
        wait_low_m = 0;
      end
      if (take) begin
        cur_m       = q_m.pop_front();
        in_flight_m = 1;
      end
      if (wr_en) begin
        if (was_full) ovf_m = 1;
        else q_m.push_back(wr_data);
      end
      done_prev_m = tx_done;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cycle_cmp();
    chk("count",    32'(count),    32'(q_m.size()));
    chk("full",     32'(full),     32'(q_m.size() == DEPTH));
    chk("empty",    32'(empty),    32'(q_m.size() == 0));
    chk("overflow", 32'(overflow), 32'(ovf_m));
    chk("tx_newd",  32'(tx_newd),  32'(in_flight_m));
    chk("tx_data",  32'(tx_data),  32'(cur_m));
    chk("busy",     32'(busy),     32'(in_flight_m || wait_low_m));
`ifdef UART_TX_FIFO_STATS_EN
    chk("sent_count", 32'(sent_count), 32'(sent_m));
    chk("hwm",        32'(hwm),        32'(hwm_m));
`endif
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    if (chk_en) cycle_cmp();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    wr_en = 1'b0;
    step();
    rst   = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int peak, full_seen, base, n, pct;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    man_done = 1'b0; xm_auto = 1'b0; xm_rand = 1'b0; xm_lat = 1; xm_wid = 1;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state
    chk("rst count",    32'(count),    0);
    chk("rst empty",    32'(empty),    1);
    chk("rst full",     32'(full),     0);
    chk("rst overflow", 32'(overflow), 0);
    chk("rst tx_newd",  32'(tx_newd),  0);
    chk("rst tx_data",  32'(tx_data),  0);
    chk("rst busy",     32'(busy),     0);

    // single byte, transmitter answers about 100 clk later
    xm_auto = 1'b1; xm_lat = 100; xm_wid = 3;
    step();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_en = 1'b0;
    chk("t1 newd after write", 32'(tx_newd), 0);
    chk("t1 count after write", 32'(count), 1);
    step();
    chk("t1 newd after pop", 32'(tx_newd), 1);
    chk("t1 data after pop", 32'(tx_data), 32'h A5);
    for (int i = 0; i < 300 && !tx_done; i++) step();
    chk("t1 done seen", 32'(tx_done), 1);
    step();
    chk("t1 newd after done", 32'(tx_newd), 0);
    chk("t1 busy in gap", 32'(busy), 1);
    for (int i = 0; i < 20 && tx_done; i++) step();
    step();
    chk("t1 busy after done low", 32'(busy), 0);

    // 16-byte burst with a slow transmitter
    do_reset();
    xm_lat = 20; xm_wid = 2;
    base = frames.size();
    peak = 0; full_seen = 0;
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      step();
      if (int'(count) > peak) peak = int'(count);
      if (full) full_seen = 1;
    end
    wr_en = 1'b0;
    chk("burst peak count", 32'(peak), 15);
    chk("burst full seen", 32'(full_seen), 0);
    for (int i = 0; i < 3000 && frames.size() - base < 16; i++) step();
    repeat (20) step();
    n = frames.size() - base;
    chk("burst frame total", 32'(n), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < n) chk("burst frame order", 32'(frames[base + i]), 32'(i + 1));
      else chk("burst frame missing", 32'(i), 32'(n));
    end

    // stalled transmitter: one frame in flight, then 17 more writes
    xm_auto = 1'b0; man_done = 1'b0;
    do_reset();
    wr_en = 1'b1; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    step();
    chk("stall newd", 32'(tx_newd), 1);
    chk("stall count 0", 32'(count), 0);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h80 + i);
      step();
    end
    wr_en = 1'b0;
    chk("stall count sat", 32'(count), 16);
    chk("stall full", 32'(full), 1);
    chk("stall overflow", 32'(overflow), 1);
    repeat (10) step();
    chk("stall overflow sticky", 32'(overflow), 1);
    base = frames.size();
    xm_lat = 2; xm_wid = 1; xm_auto = 1'b1;
    for (int i = 0; i < 1000 && frames.size() - base < 17; i++) step();
    repeat (20) step();
    n = frames.size() - base;
    chk("stall frame total", 32'(n), 17);
    if (n >= 17) begin
      chk("stall first frame", 32'(frames[base]), 32'h77);
      chk("stall last frame", 32'(frames[base + 16]), 32'h8F);
    end
    chk("stall overflow after drain", 32'(overflow), 1);
    do_reset();
    chk("overflow cleared by rst", 32'(overflow), 0);

    // stale tx_done level at SEND entry
    xm_auto = 1'b0; man_done = 1'b1;
    do_reset();
    step(); step();
    wr_en = 1'b1; wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    step();
    chk("stale newd", 32'(tx_newd), 1);
    chk("stale data", 32'(tx_data), 32'h3C);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stale newd held", 32'(tx_newd), 1);
    end
    man_done = 1'b0;
    step();
    chk("stale newd after low", 32'(tx_newd), 1);
    man_done = 1'b1;
    step();
    chk("stale newd after rise", 32'(tx_newd), 0);
    chk("stale busy gap", 32'(busy), 1);
    man_done = 1'b0;
    step();
    chk("stale busy idle", 32'(busy), 0);

    // reset mid-frame with 5 bytes queued
    do_reset();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h50 + i);
      step();
    end
    wr_en = 1'b0;
    step();
    chk("midrst count", 32'(count), 5);
    chk("midrst newd", 32'(tx_newd), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst newd drop", 32'(tx_newd), 0);
    chk("midrst count 0", 32'(count), 0);
    chk("midrst empty", 32'(empty), 1);
    man_done = 1'b1;
    repeat (3) step();
    man_done = 1'b0;
    repeat (5) step();
    chk("midrst no frame", 32'(tx_newd), 0);
    chk("midrst idle", 32'(busy), 0);

    // randomized traffic with random transmitter timing and rare resets
    xm_auto = 1'b1; xm_rand = 1'b1;
    do_reset();
    pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) pct = (i % 600 == 0) ? 90 : ((i % 400 == 0) ? 10 : 50);
      rst     = ($urandom_range(0, 499) == 0);
      wr_en   = ($urandom_range(0, 99) < pct);
      wr_data = 8'($urandom);
      step();
    end
    rst = 1'b0; wr_en = 1'b0;
    repeat (300) step();
    chk("random drained", 32'(empty), 1);

`ifdef UART_TX_FIFO_STATS_EN
    xm_rand = 1'b0; xm_lat = 5; xm_wid = 2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'hC0 + i);
      step();
    end
    wr_en = 1'b0;
    repeat (100) step();
    chk("stats sent_count", 32'(sent_count), 3);
    chk("stats hwm", 32'(hwm), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Byte buffer and transmit sequencer that sits directly upstream of the UART transmitter.
- Absorbs bursts of bytes from the host side at full clk rate.
- Hands them to the transmitter one at a time using the transmitter's newd/tx_data/donetx handshake.
- Keeps exactly one frame in flight and flags host overflow.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
DATA_W, 8, byte width; must equal transmitter data width

Ports:
clk  in  1  system clock (same clk that feeds the transmitter)
rst  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe; one byte per cycle
wr_data  in  DATA_W  host byte
full  out  1  FIFO holds DEPTH entries
empty  out  1  FIFO holds 0 entries
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky; set on wr_en while full
tx_newd  out  1  to transmitter newd; level, held until frame done
tx_data  out  DATA_W  to transmitter tx_data; stable while tx_newd high
tx_done  in  1  from transmitter donetx; asynchronous-rate level pulse, one uclk period wide
busy  out  1  state != IDLE

Behaviour:
- Reset (rst=1 at posedge clk) sets the following:
  - rd/wr pointers = 0, count = 0.
  - empty = 1, full = 0, overflow = 0.
  - tx_newd = 0, tx_data = 0, busy = 0, state = IDLE.
  - tx_done edge register = 0.
- Storage: circular RAM of DEPTH x DATA_W. Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH-1 -> 0.
- Write:
  - Accepted iff wr_en && !full, using the registered full.
  - A write while full is dropped, overflow <= 1, and the RAM and pointers are unchanged.
- Pop:
  - Occurs only in the IDLE->SEND transition.
  - Simultaneous accepted write and pop leaves count unchanged and both pointers advance.
  - Write while full in the same cycle as a pop is still rejected (registered full).
- full = (count == DEPTH); empty = (count == 0). Both are registered and consistent with count every cycle.
- Edge detect: done_rise = tx_done && !tx_done_q, where tx_done_q is registered each clk.
- FSM (one-hot or binary, 3 states):
  - IDLE:
    - If !empty: tx_data <= RAM[rd_ptr], rd_ptr++, count--, tx_newd <= 1, go SEND.
    - Else stay; tx_newd = 0.
  - SEND:
    - Hold tx_newd = 1 and tx_data stable.
    - On done_rise: tx_newd <= 0, go GAP.
    - tx_done levels that are already high on entry are not edges and are ignored.
  - GAP:
    - Wait for tx_done == 0, so the transmitter is back in idle sampling newd = 0.
    - Then go IDLE.
- Latency:
  - Write into an empty FIFO while IDLE gives tx_newd = 1 two clk cycles after the write edge: one cycle for the write, one for the pop.
  - Back-to-back frames are separated by GAP plus 1 IDLE cycle of newd = 0.
- done_rise is acted on only in SEND; in IDLE/GAP it is ignored. A stray done after reset mid-frame is therefore harmless.
- Reset mid-operation:
  - Buffered bytes are discarded and tx_newd drops next cycle.
  - The frame already started by the transmitter completes on its own; this block does not re-send it.
- overflow clears only on rst.

Optional Feature:
- Macro UART_TX_FIFO_STATS_EN.
- Defined:
  - Adds output sent_count [15:0], incremented on each done_rise accepted in SEND.
  - Saturates at 16'hFFFF; reset to 0.
  - Adds output hwm [$clog2(DEPTH+1)-1:0], the high-water mark of count; reset to 0.
- Undefined: neither port exists and no counter logic is synthesized. Core behaviour is identical.

Decomposition:
- Shared package uart_pkg holds:
  - Tx FSM state typedef {IDLE, SEND, GAP}.
  - UART_DATA_W = 8.
  - Default FIFO depth constant.
- One natural sub-module: uart_sync_fifo, which holds the RAM, pointers, count, full/empty and overflow.
- uart_tx_fifo wraps it with the edge detector and FSM.

Test Plan:
- Reset then write 8'hA5, with a transmitter model pulsing tx_done 100 clk later:
  - tx_newd = 1 with tx_data = A5 two cycles after the write.
  - tx_newd = 0 one cycle after the tx_done rise.
  - busy = 0 once tx_done falls.
- Burst-write 0x01..0x10 (16 bytes, DEPTH=16) in consecutive cycles:
  - full = 1 after the 16th write if no pop has yet occurred (pop of 0x01 happens at cycle 2, so count peaks at 15).
  - The model observes frames 0x01..0x10 in order, with none repeated.
- Write 17 bytes while the transmitter is stalled (tx_done held 0):
  - count saturates at DEPTH with full = 1, and the 17th byte is dropped.
  - overflow = 1 and stays 1 until rst.
- Hold tx_done = 1 at entry to SEND (stale level):
  - No transition occurs and tx_newd stays 1 until tx_done goes 0 then 1.
- Assert rst while in SEND with 5 bytes queued:
  - The next cycle shows tx_newd = 0, count = 0, empty = 1.
  - A later tx_done pulse produces no new frame.
- With UART_TX_FIFO_STATS_EN, send 3 frames:
  - sent_count = 3.
  - hwm equals the peak occupancy reached.
